// File: rtl/axil_pkg.sv
// Shared AXI4-Lite register-bank definitions.
//
// Contents:
//   RESP_OKAY / RESP_SLVERR  response codes (zero-extend to the bus response width)
//   wstate_e / rstate_e      write and read channel FSM states
//   decode_t / axil_decode   address decode: register index plus error flag
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_SLVERR = 2'd2;

    typedef enum logic {W_IDLE, W_RESP} wstate_e;
    typedef enum logic {R_IDLE, R_DATA} rstate_e;

    typedef struct packed {
        logic [31:0] idx;
        logic        err;
    } decode_t;

    // Word index from the byte address; errors on misalignment, out-of-range
    // addresses, and on writes to the read-only ID register at index 0.
    function automatic decode_t axil_decode(input logic [31:0] addr,
                                            input logic        is_write,
                                            input int unsigned num_regs);
        decode_t d;
        d.idx = (addr >> 2) & (num_regs - 32'd1);
        d.err = (addr[1:0] != 2'b00) || (addr >= num_regs * 32'd4) ||
                (is_write && (d.idx == 32'd0));
        return d;
    endfunction

endpackage

// File: rtl/axil_regfile_core.sv
// Register array for the AXI4-Lite register bank.
//
// Register 0 is the constant ID_VALUE; registers 1..NUM_REGS-1 are storage.
// One write port with byte-lane merge and one combinational read port.
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   we, widx       write enable and register index
//   wdata, wstrb   write data and byte strobes
//   ridx, rdata    read index and combinational read data
//   reg_out        all registers, reg k at [k*DATA_WIDTH +: DATA_WIDTH]
//
// Build option: AXIL_REGFILE_WSTRB_EN honours wstrb per byte lane; when
// undefined, every write updates the full word.
module axil_regfile_core #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 8,
    parameter logic [31:0] ID_VALUE   = 32'hA11E_0001,
    localparam int unsigned IDX_W     = $clog2(NUM_REGS)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [IDX_W-1:0]               widx,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    input  logic [IDX_W-1:0]               ridx,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    logic [DATA_WIDTH-1:0]          regs_q [NUM_REGS-1:1];
    logic [DATA_WIDTH-1:0]          wmask;
    logic [NUM_REGS*DATA_WIDTH-1:0] reg_flat;

`ifdef AXIL_REGFILE_WSTRB_EN
    always_comb begin
        wmask = '0;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            wmask[b*8 +: 8] = {8{wstrb[b]}};
        end
    end
`else
    logic unused_wstrb;
    assign wmask        = '1;
    assign unused_wstrb = ^wstrb;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
        end else if (we) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (widx == IDX_W'(k)) begin
                    regs_q[k] <= (regs_q[k] & ~wmask) | (wdata & wmask);
                end
            end
        end
    end

    always_comb begin
        reg_flat = '0;
        reg_flat[0 +: DATA_WIDTH] = DATA_WIDTH'(ID_VALUE);
        for (int k = 1; k < NUM_REGS; k++) begin
            reg_flat[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

    assign rdata   = reg_flat[ridx*DATA_WIDTH +: DATA_WIDTH];
    assign reg_out = reg_flat;

endmodule

// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register bank.
//
// Terminates AXI4-Lite reads and writes into NUM_REGS 32-bit registers and
// exposes all of them on reg_out. Register 0 is a read-only ID register.
// All ready/valid outputs are registered; read and write channels are
// independent. A same-edge read of a register being written returns the
// old value.
//
// Ports:
//   s_axi_aclk, s_axi_areset   clock, synchronous active-high reset
//   s_axi_aw*, s_axi_w*        write address / data channels
//   s_axi_b*                   write response channel
//   s_axi_ar*, s_axi_r*        read address / data channels
//   reg_out                    register contents, reg k at [k*32 +: 32]
//
// Build option: AXIL_REGFILE_WSTRB_EN enables byte-strobe writes.
module axil_slave_regfile
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned RESP_WIDTH = 3,
    parameter int unsigned NUM_REGS   = 8,
    parameter logic [31:0] ID_VALUE   = 32'hA11E_0001
) (
    input  logic                           s_axi_aclk,
    input  logic                           s_axi_areset,
    input  logic [ADDR_WIDTH-1:0]          s_axi_awaddr,
    input  logic                           s_axi_awvalid,
    output logic                           s_axi_awready,
    input  logic [DATA_WIDTH-1:0]          s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_axi_wstrb,
    input  logic                           s_axi_wvalid,
    output logic                           s_axi_wready,
    output logic [RESP_WIDTH-1:0]          s_axi_bresp,
    output logic                           s_axi_bvalid,
    input  logic                           s_axi_bready,
    input  logic [ADDR_WIDTH-1:0]          s_axi_araddr,
    input  logic                           s_axi_arvalid,
    output logic                           s_axi_arready,
    output logic [DATA_WIDTH-1:0]          s_axi_rdata,
    output logic [RESP_WIDTH-1:0]          s_axi_rresp,
    output logic                           s_axi_rvalid,
    input  logic                           s_axi_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

    localparam int unsigned IDX_W = $clog2(NUM_REGS);

    wstate_e                 w_state_q;
    logic                    awready_q, wready_q, bvalid_q;
    logic [ADDR_WIDTH-1:0]   awaddr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [RESP_WIDTH-1:0]   bresp_q;

    rstate_e                 r_state_q;
    logic                    arready_q, rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [RESP_WIDTH-1:0]   rresp_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic                    have_aw, have_w, wr_fire, we;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;
    logic [DATA_WIDTH/8-1:0] wr_strb;
    decode_t                 wr_dec, rd_dec;
    logic [DATA_WIDTH-1:0]   core_rdata;
    logic                    unused_dec;

    assign aw_hs = s_axi_awvalid & awready_q;
    assign w_hs  = s_axi_wvalid & wready_q;
    assign ar_hs = s_axi_arvalid & arready_q;

    // In W_IDLE a dropped ready means that beat is already captured.
    assign have_aw = aw_hs | ~awready_q;
    assign have_w  = w_hs | ~wready_q;
    assign wr_fire = (w_state_q == W_IDLE) & have_aw & have_w;

    // Beats arriving this cycle bypass their capture registers.
    assign wr_addr = aw_hs ? s_axi_awaddr : awaddr_q;
    assign wr_data = w_hs ? s_axi_wdata : wdata_q;
    assign wr_strb = w_hs ? s_axi_wstrb : wstrb_q;

    assign wr_dec = axil_decode(32'(wr_addr), 1'b1, NUM_REGS);
    assign rd_dec = axil_decode(32'(s_axi_araddr), 1'b0, NUM_REGS);
    assign we     = wr_fire & ~wr_dec.err;

    assign unused_dec = ^{wr_dec.idx[31:IDX_W], rd_dec.idx[31:IDX_W]};

    axil_regfile_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_REGS   (NUM_REGS),
        .ID_VALUE   (ID_VALUE)
    ) u_core (
        .clk     (s_axi_aclk),
        .rst     (s_axi_areset),
        .we      (we),
        .widx    (wr_dec.idx[IDX_W-1:0]),
        .wdata   (wr_data),
        .wstrb   (wr_strb),
        .ridx    (rd_dec.idx[IDX_W-1:0]),
        .rdata   (core_rdata),
        .reg_out (reg_out)
    );

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) begin
                        awaddr_q  <= s_axi_awaddr;
                        awready_q <= 1'b0;
                    end
                    if (w_hs) begin
                        wdata_q  <= s_axi_wdata;
                        wstrb_q  <= s_axi_wstrb;
                        wready_q <= 1'b0;
                    end
                    if (wr_fire) begin
                        w_state_q <= W_RESP;
                        bvalid_q  <= 1'b1;
                        bresp_q   <= wr_dec.err ? RESP_WIDTH'(RESP_SLVERR)
                                                : RESP_WIDTH'(RESP_OKAY);
                    end
                end
                W_RESP: begin
                    if (s_axi_bready) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s_axi_aclk) begin
        if (s_axi_areset) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_dec.err ? '0 : core_rdata;
                        rresp_q   <= rd_dec.err ? RESP_WIDTH'(RESP_SLVERR)
                                                : RESP_WIDTH'(RESP_OKAY);
                    end
                end
                R_DATA: begin
                    if (s_axi_rready) begin
                        r_state_q <= R_IDLE;
                        arready_q <= 1'b1;
                        rvalid_q  <= 1'b0;
                    end
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Directed testbench for axil_slave_regfile (default parameters).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_axil_slave_regfile;

    localparam logic [31:0] ID = 32'hA11E_0001;

    logic         clk = 1'b0;
    logic         areset;
    logic [7:0]   awaddr, araddr;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  wdata, rdata;
    logic [3:0]   wstrb;
    logic [2:0]   bresp, rresp;
    logic [255:0] reg_out;

    int n_tests = 0;
    int n_fail  = 0;

    axil_slave_regfile dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (areset),
        .s_axi_awaddr  (awaddr),
        .s_axi_awvalid (awvalid),
        .s_axi_awready (awready),
        .s_axi_wdata   (wdata),
        .s_axi_wstrb   (wstrb),
        .s_axi_wvalid  (wvalid),
        .s_axi_wready  (wready),
        .s_axi_bresp   (bresp),
        .s_axi_bvalid  (bvalid),
        .s_axi_bready  (bready),
        .s_axi_araddr  (araddr),
        .s_axi_arvalid (arvalid),
        .s_axi_arready (arready),
        .s_axi_rdata   (rdata),
        .s_axi_rresp   (rresp),
        .s_axi_rvalid  (rvalid),
        .s_axi_rready  (rready),
        .reg_out       (reg_out)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // AW and W in the same cycle, response accepted right away.
    task automatic axi_write(input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [2:0] resp);
        awaddr  = addr;
        wdata   = data;
        wstrb   = strb;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq("b_latency", 32'(bvalid), 32'd1);
        resp   = bresp;
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq("b_done_awready", 32'(awready), 32'd1);
    endtask

    task automatic axi_read(input logic [7:0] addr, output logic [31:0] data,
                            output logic [2:0] resp);
        araddr  = addr;
        arvalid = 1'b1;
        tick();
        arvalid = 1'b0;
        check_eq("r_latency", 32'(rvalid), 32'd1);
        data   = rdata;
        resp   = rresp;
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_eq("r_done_arready", 32'(arready), 32'd1);
    endtask

    logic [2:0]  resp;
    logic [31:0] data;

    initial begin
        areset  = 1'b1;
        awaddr  = '0;
        araddr  = '0;
        wdata   = '0;
        wstrb   = 4'hF;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        arvalid = 1'b0;
        rready  = 1'b0;
        tick();
        tick();
        areset = 1'b0;

        check_eq("rst_awready", 32'(awready), 32'd1);
        check_eq("rst_wready", 32'(wready), 32'd1);
        check_eq("rst_arready", 32'(arready), 32'd1);
        check_eq("rst_bvalid", 32'(bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(rvalid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_reg0", reg_out[31:0], ID);

        axi_read(8'h00, data, resp);
        check_eq("rd_id_resp", 32'(resp), 32'd0);
        check_eq("rd_id_data", data, ID);
        axi_read(8'h04, data, resp);
        check_eq("rd_r1_reset", data, 32'd0);

        axi_write(8'h04, 32'h0000_0023, 4'hF, resp);
        check_eq("wr_r1_resp", 32'(resp), 32'd0);
        check_eq("wr_r1_regout", reg_out[63:32], 32'h23);
        axi_read(8'h04, data, resp);
        check_eq("rd_r1_data", data, 32'h23);

        // W first, AW three cycles later, B held off for four cycles.
        wdata  = 32'h0000_002A;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        tick();
        wvalid = 1'b0;
        check_eq("wfirst_wready", 32'(wready), 32'd0);
        check_eq("wfirst_awready", 32'(awready), 32'd1);
        check_eq("wfirst_bvalid", 32'(bvalid), 32'd0);
        tick();
        tick();
        awaddr  = 8'h10;
        awvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        check_eq("wfirst_b_latency", 32'(bvalid), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("hold_bvalid", 32'(bvalid), 32'd1);
            check_eq("hold_bresp", 32'(bresp), 32'd0);
            check_eq("hold_awready", 32'(awready), 32'd0);
            check_eq("hold_wready", 32'(wready), 32'd0);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq("hold_b_done", 32'(bvalid), 32'd0);
        check_eq("hold_awready_ret", 32'(awready), 32'd1);
        check_eq("hold_wready_ret", 32'(wready), 32'd1);
        check_eq("hold_r4", reg_out[4*32 +: 32], 32'h2A);

        axi_write(8'h00, 32'hDEAD_BEEF, 4'hF, resp);
        check_eq("err_wr_id_resp", 32'(resp), 32'd2);
        check_eq("err_wr_id_keep", reg_out[31:0], ID);
        axi_write(8'h06, 32'h0000_0099, 4'hF, resp);
        check_eq("err_wr_misalign", 32'(resp), 32'd2);
        check_eq("err_wr_misalign_r1", reg_out[63:32], 32'h23);
        axi_read(8'h20, data, resp);
        check_eq("err_rd_range_resp", 32'(resp), 32'd2);
        check_eq("err_rd_range_data", data, 32'd0);

        axi_write(8'h14, 32'hFFFF_FFFF, 4'hF, resp);
        axi_write(8'h14, 32'h1234_5678, 4'b0101, resp);
        check_eq("strb_resp", 32'(resp), 32'd0);
`ifdef AXIL_REGFILE_WSTRB_EN
        check_eq("strb_r5", reg_out[5*32 +: 32], 32'hFF34_FF78);
`else
        check_eq("strb_r5", reg_out[5*32 +: 32], 32'h1234_5678);
`endif

        // Same-edge read and write of reg 1: read sees the old value.
        awaddr  = 8'h04;
        wdata   = 32'h0000_0055;
        wstrb   = 4'hF;
        araddr  = 8'h04;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        arvalid = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b0;
        check_eq("rw_rvalid", 32'(rvalid), 32'd1);
        check_eq("rw_bvalid", 32'(bvalid), 32'd1);
        check_eq("rw_old_data", rdata, 32'h23);
        bready = 1'b1;
        rready = 1'b1;
        tick();
        bready = 1'b0;
        rready = 1'b0;
        check_eq("rw_new_r1", reg_out[63:32], 32'h55);

        // Reset while the write response is pending.
        awaddr  = 8'h08;
        wdata   = 32'h0000_0077;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        tick();
        awvalid = 1'b0;
        wvalid  = 1'b0;
        check_eq("rstmid_bvalid_pre", 32'(bvalid), 32'd1);
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check_eq("rstmid_bvalid", 32'(bvalid), 32'd0);
        check_eq("rstmid_awready", 32'(awready), 32'd1);
        check_eq("rstmid_wready", 32'(wready), 32'd1);
        check_eq("rstmid_reg0", reg_out[31:0], ID);
        for (int k = 1; k < 8; k++) begin
            check_eq("rstmid_regk", reg_out[k*32 +: 32], 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
